vote_judge: RTL and testbench
=============================

# vote_judge

Parametrised, clocked N-voter judging unit; the sequential successor to the team's 3-input combinational majority gate. A START pulse opens a voting session. Each voter casts one sticky vote, and the session closes when every voter has voted or a timeout expires. The block then tallies the yes-votes against a configurable threshold and reports a registered PASS/FAIL result with a one-cycle DONE strobe. It sits between the keypad/switch debounce logic and the display/LED driver on the lab board.

## Interface
- N, 5, number of voters; legal range 1..16
- THRESH, 3, minimum yes-count for PASS; legal range 1..N
- TIMEOUT, 255, maximum COLLECT length in cycles; legal range 1..65535
- CLK  input  1  system clock; rising edge
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  session-open request; sampled only in IDLE
- VALID  input  N  per-voter cast strobe; bit i = voter i casting this cycle
- VOTE  input  N  per-voter ballot; 1 = yes, meaningful only with VALID[i]
- BUSY  output  1  high in COLLECT, TALLY and RESULT
- DONE  output  1  one-cycle strobe in RESULT
- PASS  output  1  registered verdict
- TIMED_OUT  output  1  session closed by timeout rather than full turnout
- YES_CNT  output  CW  registered yes-count; CW = $clog2(N+1)
- Clocking is decided: single clock CLK; RST_N is asynchronous, active-low.

## Operation
- FSM states: IDLE, COLLECT, TALLY, RESULT. Encoding is free.
- IDLE -> COLLECT when START=1.
  - Clear cast_mask, yes_mask and the timer.
  - VALID/VOTE in the START cycle are ignored.
- In COLLECT, each edge applies:
  - new = VALID & ~cast_mask
  - cast_mask |= new
  - yes_mask |= new & VOTE
- Votes are first-cast-wins; repeat VALID from a voter who has already cast is ignored.
- COLLECT -> TALLY on the edge where the updated cast_mask is all ones, or where timer == TIMEOUT-1.
  - Votes sampled on that edge still count.
  - Timer increments once per COLLECT cycle.
- In TALLY (one cycle), at the TALLY -> RESULT edge:
  - YES_CNT <= popcount(yes_mask)
  - PASS <= (popcount >= THRESH)
  - TIMED_OUT <= (cast_mask != all ones)
- RESULT -> IDLE unconditionally after one cycle. DONE = (state == RESULT).
- PASS, YES_CNT and TIMED_OUT hold until the next session's TALLY -> RESULT edge.
- Non-voters count as no; THRESH is absolute, not relative to turnout.
- START outside IDLE is ignored; it is not queued.
- If full turnout and timeout occur on the same edge, take the full-turnout path: TIMED_OUT = 0.

## Timing
- Reset values: state IDLE, BUSY 0, DONE 0, PASS 0, TIMED_OUT 0, YES_CNT 0, all masks and the timer 0.
- RST_N assertion mid-session aborts immediately: no DONE, and result registers clear.
- Best-case latency: START sampled at edge e0 with all votes on the first COLLECT edge e1 gives TALLY at e1 -> e2 and DONE high during the cycle after e2. That is 3 cycles from START to DONE.
- Worst case: DONE is TIMEOUT+2 cycles after the START edge.
- BUSY rises the cycle after START is sampled and falls the cycle after DONE.
- Minimum START-to-START spacing is 4 cycles.
- All outputs are registered or decoded directly from the state register, with no input-to-output combinational path.

## Configuration
- VOTE_VETO_EN:
  - Defined: voter 0 is chair. If voter 0 cast a no vote (cast_mask[0]=1, yes_mask[0]=0), PASS = 0 regardless of count. YES_CNT is still reported unmodified. A chair who did not vote does not veto.
  - Undefined: all voters are equal and PASS depends on count only.

## Test plan
All scenarios use N=5, THRESH=3, TIMEOUT=8.
- Reset, then START with VALID=5'b11111 and VOTE=5'b00111 on the first COLLECT cycle -> DONE 3 cycles after START; PASS=1, YES_CNT=3, TIMED_OUT=0.
- Votes spread over cycles. Voter 1 casts yes twice, then no; the other voters cast no -> voter 1's first yes counts; YES_CNT=1, PASS=0.
- Only voters 0..2 cast, all yes; no further VALID -> COLLECT lasts 8 cycles; YES_CNT=3, PASS=1, TIMED_OUT=1.
- Last vote lands on timer==7 -> TIMED_OUT=0, and that vote is counted.
- START pulsed during COLLECT; VALID asserted in the START cycle; RST_N dropped mid-COLLECT -> no extra session is opened; the START-cycle votes are ignored; reset forces BUSY=0, PASS=0, YES_CNT=0 asynchronously.
- VOTE_VETO_EN defined, VOTE=5'b11110 with all voters valid -> YES_CNT=4, PASS=0. Same stimulus with the macro undefined -> PASS=1.

Source files
------------

// File: rtl/vote_judge.sv
// N-voter judging unit: START opens a session, sticky first-cast votes, close on full turnout or timeout, registered verdict.
// Latency: 3 cycles START-to-DONE best case, TIMEOUT+2 worst case. Backpressure: none; START outside IDLE is dropped, not queued.
// Optional VOTE_VETO_EN: voter 0 is chair and a cast "no" from the chair forces PASS low.
module vote_judge #(
    parameter int N       = 5,
    parameter int THRESH  = 3,
    parameter int TIMEOUT = 255,
    localparam int CW     = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  valid,
    input  logic [N-1:0]  vote,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timed_out,
    output logic [CW-1:0] yes_cnt
);

    typedef enum logic [1:0] {IDLE, COLLECT, TALLY, RESULT} state_t;

    localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [N-1:0] cast_mask;
    logic [N-1:0] yes_mask;
    logic [15:0]  timer;

    logic [N-1:0]  new_cast;
    logic [N-1:0]  cast_nxt;
    logic [CW-1:0] yes_pop;
    logic          count_ok;
    logic          verdict;

    always_comb begin
        new_cast = valid & ~cast_mask;
        cast_nxt = cast_mask | new_cast;
        yes_pop  = '0;
        for (int i = 0; i < N; i++) begin
            yes_pop = yes_pop + CW'(yes_mask[i]);
        end
        count_ok = (int'(yes_pop) >= THRESH);
`ifdef VOTE_VETO_EN
        // An absent chair does not veto; only a cast "no" does.
        verdict  = count_ok && !(cast_mask[0] && !yes_mask[0]);
`else
        verdict  = count_ok;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cast_mask <= '0;
            yes_mask  <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
            yes_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COLLECT;
                        busy      <= 1'b1;
                        cast_mask <= '0;
                        yes_mask  <= '0;
                        timer     <= '0;
                    end
                end
                COLLECT: begin
                    cast_mask <= cast_nxt;
                    yes_mask  <= yes_mask | (new_cast & vote);
                    timer     <= timer + 16'd1;
                    // Votes landing on the closing edge still count.
                    if ((&cast_nxt) || (timer == T_LAST)) begin
                        state <= TALLY;
                    end
                end
                TALLY: begin
                    state     <= RESULT;
                    done      <= 1'b1;
                    yes_cnt   <= yes_pop;
                    pass      <= verdict;
                    timed_out <= ~(&cast_mask);
                end
                RESULT: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_judge.sv
// Directed bench for vote_judge with N=5, THRESH=3, TIMEOUT=8; expected verdicts queued at stimulus time, popped at DONE.
// Expected PASS for the chair-veto case follows whether VOTE_VETO_EN is defined for this build.
module tb_vote_judge;

`ifdef VOTE_VETO_EN
    localparam bit VETO = 1'b1;
`else
    localparam bit VETO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] valid = '0;
    logic [4:0] vote = '0;
    logic       busy, done, pass, timed_out;
    logic [2:0] yes_cnt;

    typedef struct {
        logic       pass;
        logic [2:0] yes;
        logic       to;
        int         lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t0 = 0;

    vote_judge #(.N(5), .THRESH(3), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .vote(vote),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out), .yes_cnt(yes_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // START cycle with the given (to-be-ignored) VALID/VOTE.
    task automatic open_session(input logic [4:0] v, input logic [4:0] b);
        start = 1'b1; valid = v; vote = b;
        tick();
        start = 1'b0; valid = '0; vote = '0;
        t0 = cyc;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic cast(input logic [4:0] v, input logic [4:0] b);
        valid = v; vote = b;
        tick();
        valid = '0; vote = '0;
    endtask

    task automatic expect_result(input logic p, input logic [2:0] y, input logic to, input int lat);
        exp_t e;
        e.pass = p; e.yes = y; e.to = to; e.lat = lat;
        q.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(q.size() > 0), 32'd1);
        if (done === 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_latency"}, 32'(cyc - t0), 32'(e.lat));
            check({tag, "_pass"}, 32'(pass), 32'(e.pass));
            check({tag, "_yes_cnt"}, 32'(yes_cnt), 32'(e.yes));
            check({tag, "_timed_out"}, 32'(timed_out), 32'(e.to));
        end
        tick();
        check({tag, "_done_strobe"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_to", 32'(timed_out), 32'd0);
        check("rst_yes", 32'(yes_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full turnout on first COLLECT cycle.
        open_session(5'b00000, 5'b00000);
        expect_result(1'b1, 3'd3, 1'b0, 2);
        cast(5'b11111, 5'b00111);
        wait_done("s1");
        tick();

        // Spread votes; voter 1 first-cast yes sticks.
        open_session(5'b00000, 5'b00000);
        check("s2_hold_yes", 32'(yes_cnt), 32'd3);
        check("s2_hold_pass", 32'(pass), 32'd1);
        expect_result(1'b0, 3'd1, 1'b0, 5);
        cast(5'b00010, 5'b00010);
        cast(5'b00010, 5'b00010);
        cast(5'b00010, 5'b00000);
        cast(5'b11101, 5'b00000);
        wait_done("s2");

        // Partial turnout closes by timeout.
        open_session(5'b00000, 5'b00000);
        expect_result(1'b1, 3'd3, 1'b1, 9);
        cast(5'b00111, 5'b00111);
        wait_done("s3");

        // Last vote on timer==7 completes turnout.
        open_session(5'b00000, 5'b00000);
        expect_result(1'b1, 3'd5, 1'b0, 9);
        cast(5'b01111, 5'b01111);
        for (int i = 0; i < 6; i++) cast(5'b00000, 5'b00000);
        cast(5'b10000, 5'b10000);
        wait_done("s4");

        // Asynchronous abort mid-COLLECT.
        open_session(5'b00000, 5'b00000);
        cast(5'b00011, 5'b00011);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pass", 32'(pass), 32'd0);
        check("arst_yes", 32'(yes_cnt), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("arst_no_session", 32'(seen), 32'd0);

        // START-cycle votes ignored; START during COLLECT ignored.
        open_session(5'b11111, 5'b11111);
        expect_result(1'b0, 3'd1, 1'b0, 3);
        start = 1'b1;
        cast(5'b00000, 5'b00000);
        start = 1'b0;
        cast(5'b11111, 5'b00001);
        wait_done("s5");
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy === 1'b1) seen++;
        end
        check("s5_no_queued_start", 32'(seen), 32'd0);

        // Chair votes no with four yes overall.
        open_session(5'b00000, 5'b00000);
        expect_result(!VETO, 3'd4, 1'b0, 2);
        cast(5'b11111, 5'b11110);
        wait_done("s6");

        check("sb_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
